// File: rtl/fft_bitrev_reorder.sv
// Reorder buffer for the 128-point SDF FFT: writes bit-reversed frames into a ping-pong RAM and reads them back in natural order.
// Optional macro FFT_REORDER_BYPASS_EN adds a Bypass input that writes each sample at wr_cnt (natural order passthrough).
//
// state   | meaning
// RD_IDLE | no frame being drained; waits for a full bank
// RD_RUN  | draining rd_bank; output register advances on !Out_Valid || Out_Ready
module fft_bitrev_reorder #(
  parameter int BW    = 16,
  parameter int N     = 128,
  parameter int LOG2N = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BW:0]      In_Re,
  input  logic [BW:0]      In_Im,
  input  logic             valid,
`ifdef FFT_REORDER_BYPASS_EN
  input  logic             Bypass,
`endif
  output logic [BW:0]      Out_Re,
  output logic [BW:0]      Out_Im,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [LOG2N-1:0] Out_Index,
  output logic             Out_Last,
  output logic             Ovf
);

  localparam int DW = 2 * (BW + 1);
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  typedef enum logic {RD_IDLE, RD_RUN} rd_state_e;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  logic [DW-1:0]    mem_q [2*N];
  rd_state_e        state_q, state_d;
  logic [1:0]       bank_full_q, bank_full_d;
  logic             wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_q, ovf_d;
  logic [BW:0]      out_re_q, out_im_q;
  logic [LOG2N-1:0] out_idx_q;
  logic             out_last_q;

  logic             wr_accept, wr_last, rd_load, rd_last;
  logic [LOG2N-1:0] wr_addr, rd_addr;

  always_comb begin
    wr_accept = valid && !bank_full_q[wr_bank_q];
    wr_last   = wr_accept && (wr_cnt_q == LAST_IDX);
`ifdef FFT_REORDER_BYPASS_EN
    wr_addr   = Bypass ? wr_cnt_q : bitrev(wr_cnt_q);
`else
    wr_addr   = bitrev(wr_cnt_q);
`endif
    wr_bank_d = wr_bank_q;
    wr_cnt_d  = wr_cnt_q;
    if (wr_accept) begin
      wr_cnt_d = wr_last ? '0 : wr_cnt_q + LOG2N'(1);
      if (wr_last) wr_bank_d = ~wr_bank_q;
    end
    ovf_d = ovf_q | (valid && bank_full_q[wr_bank_q]);
  end

  always_comb begin
    state_d     = state_q;
    rd_load     = 1'b0;
    rd_addr     = rd_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    rd_bank_d   = rd_bank_q;
    out_valid_d = out_valid_q;
    case (state_q)
      RD_IDLE: begin
        rd_addr = '0;
        // a pending last sample of the previous frame must not be overwritten
        if (bank_full_q[rd_bank_q] && (!out_valid_q || Out_Ready)) begin
          rd_load = 1'b1;
          state_d = RD_RUN;
        end else if (out_valid_q && Out_Ready) begin
          out_valid_d = 1'b0;
        end
      end
      RD_RUN: begin
        if (!out_valid_q || Out_Ready) rd_load = 1'b1;
      end
      default: state_d = RD_IDLE;
    endcase
    rd_last = rd_load && (rd_addr == LAST_IDX);
    if (rd_load) begin
      out_valid_d = 1'b1;
      rd_cnt_d    = rd_last ? '0 : rd_addr + LOG2N'(1);
    end
    if (rd_last) begin
      rd_bank_d = ~rd_bank_q;
      state_d   = bank_full_q[~rd_bank_q] ? RD_RUN : RD_IDLE;
    end
  end

  // write-set and read-clear always hit different banks
  always_comb begin
    bank_full_d = bank_full_q;
    if (wr_last) bank_full_d[wr_bank_q] = 1'b1;
    if (rd_last) bank_full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[{wr_bank_q, wr_addr}] <= {In_Re, In_Im};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RD_IDLE;
      bank_full_q <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      if (rd_load) begin
        {out_re_q, out_im_q} <= mem_q[{rd_bank_q, rd_addr}];
        out_idx_q  <= rd_addr;
        out_last_q <= (rd_addr == LAST_IDX);
      end
    end
  end

  assign Out_Re    = out_re_q;
  assign Out_Im    = out_im_q;
  assign Out_Valid = out_valid_q;
  assign Out_Index = out_idx_q;
  assign Out_Last  = out_last_q;
  assign Ovf       = ovf_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: frame-level queue model checked every cycle, plus directed ordering/latency checks.
module tb_fft_bitrev_reorder;
  localparam int BW = 16, N = 128, LOG2N = 7;

  logic clk = 1'b0;
  logic reset, valid, Out_Ready, Out_Valid, Out_Last, Ovf;
  logic [BW:0] In_Re, In_Im, Out_Re, Out_Im;
  logic [LOG2N-1:0] Out_Index;

  always #5 clk = ~clk;

  fft_bitrev_reorder #(.BW(BW), .N(N), .LOG2N(LOG2N)) dut (
    .clk(clk), .reset(reset), .In_Re(In_Re), .In_Im(In_Im), .valid(valid),
`ifdef FFT_REORDER_BYPASS_EN
    .Bypass(1'b0),
`endif
    .Out_Re(Out_Re), .Out_Im(Out_Im), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Out_Index(Out_Index), .Out_Last(Out_Last), .Ovf(Ovf));

  int tests = 0, fails = 0, cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int brev(input int a);
    int r = 0;
    for (int i = 0; i < LOG2N; i++) if (((a >> i) & 1) != 0) r |= 1 << (LOG2N - 1 - i);
    return r;
  endfunction

  // Behavioural model: two-frame buffer holding natural-order samples plus one output register.
  typedef struct { logic [BW:0] re; logic [BW:0] im; int idx; } smp_t;
  smp_t ram_q[$];
  smp_t cur[N];
  smp_t m_out;
  int   wcnt;
  bit   m_ov, m_ovf;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_q.delete();
      wcnt = 0; m_ov = 0; m_ovf = 0;
      m_out = '{re: '0, im: '0, idx: 0};
    end else begin
      int fullc;
      fullc = (ram_q.size() + N - 1) / N;
      if (ram_q.size() > 0 && (!m_ov || Out_Ready)) begin
        m_out = ram_q.pop_front();
        m_ov = 1;
      end else if (m_ov && Out_Ready) begin
        m_ov = 0;
      end
      if (valid) begin
        if (fullc == 2) m_ovf = 1;
        else begin
          cur[brev(wcnt)] = '{re: In_Re, im: In_Im, idx: brev(wcnt)};
          wcnt++;
          if (wcnt == N) begin
            for (int k = 0; k < N; k++) ram_q.push_back(cur[k]);
            wcnt = 0;
          end
        end
      end
    end
  end

  logic [BW:0] got_re[$], got_im[$];
  int got_idx[$], got_cyc[$];
  bit got_last[$];

  always @(negedge clk) begin
    cyc++;
    chk("out_valid", Out_Valid, m_ov);
    chk("ovf", Ovf, m_ovf);
    if (m_ov) begin
      chk("out_re", Out_Re, m_out.re);
      chk("out_im", Out_Im, m_out.im);
      chk("out_index", Out_Index, m_out.idx);
      chk("out_last", Out_Last, m_out.idx == N - 1);
    end
    if (!reset && Out_Valid && Out_Ready) begin
      got_re.push_back(Out_Re); got_im.push_back(Out_Im);
      got_idx.push_back(Out_Index); got_last.push_back(Out_Last);
      got_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_got();
    got_re.delete(); got_im.delete(); got_idx.delete(); got_last.delete(); got_cyc.delete();
  endtask

  task automatic wait_xfers(input int n, input int budget, input string name);
    int c = 0;
    while (got_re.size() < n && c < budget) begin step(); c++; end
    repeat (5) step();
    chk(name, got_re.size(), n);
  endtask

  task automatic drive(input int re, input int im);
    valid = 1'b1; In_Re = (BW+1)'(re); In_Im = (BW+1)'(im);
  endtask

  // Checks the single-frame pattern: Out_Re = k, Out_Im = bitrev(k), Last only at 127.
  task automatic check_ramp(input string name, input int base);
    int errs = 0;
    for (int k = 0; k < got_re.size() && k < N; k++)
      if (got_re[k] != (BW+1)'(base + k) || got_im[k] != (BW+1)'(brev(k)) ||
          got_idx[k] != k || got_last[k] != (k == N - 1)) errs++;
    chk(name, errs, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int errs, acc;
    reset = 1'b1; valid = 1'b0; In_Re = '0; In_Im = '0; Out_Ready = 1'b0;
    #1;
    chk("rst_valid", Out_Valid, 0);
    chk("rst_ovf", Ovf, 0);
    chk("rst_index", Out_Index, 0);
    chk("rst_last", Out_Last, 0);
    repeat (3) step();
    reset = 1'b0;
    repeat (20) step();
    chk("idle_valid", Out_Valid, 0);

    // single frame
    clear_got(); Out_Ready = 1'b1;
    for (int p = 0; p < N; p++) begin drive(brev(p), p); step(); end
    chk("lat_pre", Out_Valid, 0);
    valid = 1'b0;
    step();
    chk("lat_post", Out_Valid, 1);
    chk("lat_first_idx", Out_Index, 0);
    wait_xfers(N, 200, "single_count");
    check_ramp("single_order", 0);

    // back-to-back frames, continuous valid
    clear_got();
    for (int i = 0; i < 3 * N; i++) begin
      r = $urandom; drive(int'(r[BW:0]), int'(r[31:15])); step();
    end
    valid = 1'b0;
    wait_xfers(3 * N, 600, "b2b_count");
    if (got_cyc.size() == 3 * N) chk("b2b_gapless", got_cyc[3*N-1] - got_cyc[0], 3 * N - 1);
    chk("b2b_ovf", Ovf, 0);

    // backpressure and overflow
    clear_got(); Out_Ready = 1'b0;
    for (int f = 0; f < 3; f++)
      for (int p = 0; p < N; p++) begin drive(f * N + p, brev(p)); step(); end
    valid = 1'b0;
    chk("bp_hold_valid", Out_Valid, 1);
    chk("bp_hold_index", Out_Index, 0);
    chk("bp_hold_re", Out_Re, 0);
    chk("bp_ovf", Ovf, 1);
    Out_Ready = 1'b1;
    wait_xfers(2 * N, 400, "bp_count");
    errs = 0;
    for (int i = 0; i < got_re.size(); i++)
      if (got_re[i] != (BW+1)'((i / N) * N + brev(i % N)) || got_im[i] != (BW+1)'(i % N)) errs++;
    chk("bp_order", errs, 0);

    // gapped input: one accept every third cycle
    clear_got();
    for (int p = 0; p < N; p++) begin
      drive(brev(p), p); step();
      valid = 1'b0; step(); step();
    end
    wait_xfers(N, 200, "gap_count");
    check_ramp("gap_order", 0);

    // reset mid-frame with a held output pending
    Out_Ready = 1'b0;
    for (int p = 0; p < N + 60; p++) begin drive(p, p); step(); end
    valid = 1'b0;
    chk("mid_pre_valid", Out_Valid, 1);
    #3 reset = 1'b1;
    #1;
    chk("async_valid", Out_Valid, 0);
    chk("async_ovf", Ovf, 0);
    chk("async_index", Out_Index, 0);
    step(); step();
    reset = 1'b0;
    repeat (20) step();
    chk("post_rst_idle", Out_Valid, 0);
    clear_got(); Out_Ready = 1'b1;
    for (int p = 0; p < N; p++) begin drive(200 + brev(p), p); step(); end
    valid = 1'b0;
    wait_xfers(N, 200, "mid_count");
    check_ramp("mid_order", 200);

    // randomized traffic with random backpressure
    clear_got();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      valid = (r[1:0] != 2'b00);
      In_Re = r[BW:0]; In_Im = r[31:15];
      Out_Ready = (i < 1500) ? (r[20:18] != 3'b000) : (r[22:21] == 2'b00);
      step();
    end
    valid = 1'b0; Out_Ready = 1'b1;
    acc = 0;
    while ((ram_q.size() > 0 || m_ov) && acc < 600) begin step(); acc++; end
    step();
    chk("rand_drain", Out_Valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Output reorder buffer for the 128-point SDF FFT.
- Frames leave the last butterfly/shift-register stage in bit-reversed order and are written into a ping-pong RAM at bit-reversed addresses.
- Frames are read back in natural order with a valid/ready output handshake.
- Decouples the free-running FFT pipeline from downstream consumers; a sticky flag reports any dropped samples.

Parameters:
- BW, 16, MSB index of each data component; each component is BW+1 bits, matching the FFT datapath.
- N, 128, frame length in points; must be a power of two.
- LOG2N, 7, log2(N); width of the index counters.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- In_Re  input  BW+1  real part of the input sample, bit-reversed order.
- In_Im  input  BW+1  imaginary part of the input sample.
- valid  input  1  input sample present this cycle; no input backpressure.
- Out_Re  output  BW+1  real part, natural order.
- Out_Im  output  BW+1  imaginary part, natural order.
- Out_Valid  output  1  output register holds a sample.
- Out_Ready  input  1  consumer accepts the sample this cycle.
- Out_Index  output  LOG2N  natural frequency index of the current output.
- Out_Last  output  1  high when Out_Index == N-1.
- Ovf  output  1  sticky overflow flag; cleared only by reset.

Behaviour:
- Reset (asynchronous, immediate):
  - Out_Valid, Out_Last, Ovf, Out_Re, Out_Im and Out_Index go to 0.
  - Both bank_full flags clear; wr_bank = rd_bank = 0; wr_cnt = rd_cnt = 0; read FSM goes to RD_IDLE.
  - RAM contents are don't-care.
  - Reset mid-frame discards all partial and complete frames.
- Write side:
  - Accept when valid && !bank_full[wr_bank]: mem[wr_bank][bitrev(wr_cnt)] <= {In_Re, In_Im}; wr_cnt++.
  - On acceptance with wr_cnt == N-1: bank_full[wr_bank] <= 1, wr_bank toggles, wr_cnt <= 0.
  - Any gap pattern on valid is legal; a frame is N accepted samples, not N cycles.
  - Overflow: if valid && bank_full[wr_bank], the sample is dropped, wr_cnt is held and Ovf <= 1. Later samples are written once the bank frees, so frame alignment after an overflow is undefined; Ovf flags this.
- Read FSM, two states:
  - RD_IDLE: if bank_full[rd_bank], load the output register from mem[rd_bank][0], set Out_Index = 0, rd_cnt <= 1, go to RD_RUN. Out_Valid rises after this edge.
  - RD_RUN: the output register advances when !Out_Valid || Out_Ready. It loads mem[rd_bank][rd_cnt], sets Out_Index = rd_cnt, rd_cnt++.
  - Last load (rd_cnt == N-1): bank_full[rd_bank] <= 0, rd_bank toggles, rd_cnt <= 0.
    - If the other bank is already full, stay in RD_RUN and continue next cycle with no bubble.
    - Otherwise go to RD_IDLE.
  - In RD_IDLE with Out_Valid && Out_Ready and no full bank: Out_Valid <= 0.
- Handshake:
  - While Out_Valid && !Out_Ready, Out_Re, Out_Im, Out_Index and Out_Last hold stable.
  - A transfer occurs on an edge with Out_Valid && Out_Ready.
- Latency: Out_Valid asserts on the edge after the one accepting sample N-1, provided the read side is idle.
- Simultaneous events: the write-set and read-clear of bank_full always target different banks in the same cycle, so both take effect.
- Throughput: with Out_Ready held high, one output per cycle sustained, and continuous valid never overflows.
- RAM: single write port and single read port, synchronous read; a read and a write in the same cycle always target different banks.

Optional Feature:
- Macro: FFT_REORDER_BYPASS_EN.
- Defined: adds input port Bypass (1 bit, sampled per accepted sample). When high, the write address is wr_cnt (natural order passthrough, still buffered and handshaked); when low, the write address is bitrev(wr_cnt).
- Undefined: no Bypass port; the write address is always bitrev(wr_cnt).

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> Out_Valid = 0, Ovf = 0 immediately; after release with valid = 0 for 20 cycles -> Out_Valid stays 0.
- Single frame: valid = 1 for 128 cycles, In_Re = bitrev7(p), In_Im = p at position p, Out_Ready = 1 -> Out_Valid rises 1 cycle after the last accept; Out_Re = 0..127 in order; Out_Im = bitrev7(Out_Re); Out_Last only at index 127.
- Back-to-back: 3 frames on continuous valid, Out_Ready = 1 -> 384 outputs with no Out_Valid gap after the first; Ovf = 0.
- Backpressure/overflow: Out_Ready = 0 from the start; feed 3 frames -> the first output holds index 0 stable; frame 3 is dropped; Ovf = 1. Then Out_Ready = 1 -> exactly 256 outputs, frames 1 then 2, in natural order.
- Gapped input: valid asserted every third cycle for 128 accepts -> same output content as the single-frame test.
- Reset mid-frame: reset after 60 accepts, then one full frame -> only that frame's 128 samples are output, correctly ordered.
